// File: rtl/i_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory handshake and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is its environment.
interface i_fetch_unit_if;
  logic        stall;
  logic        PCSrc;
  logic [31:0] EX_MEM_NPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_NPC;
  logic        IF_ID_valid;

  modport master (
    input  stall, PCSrc, EX_MEM_NPC, imem_ack, imem_rdata,
    output imem_req, imem_addr, IF_ID_Instr, IF_ID_NPC, IF_ID_valid
  );

  modport slave (
    output stall, PCSrc, EX_MEM_NPC, imem_ack, imem_rdata,
    input  imem_req, imem_addr, IF_ID_Instr, IF_ID_NPC, IF_ID_valid
  );
endinterface

// File: rtl/i_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches over a req/ack memory handshake, buffers one
// instruction while stalled and drains a killed request after a branch redirect.
module i_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  i_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HELD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_npc_q, buf_npc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_npc_q, if_id_npc_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        req_s;
  logic        ack_s;
  logic [31:0] target_s;
  logic [31:0] pc_inc_s;

  // Request is gated by rst so it drops immediately, before the async reset settles.
  assign req_s    = (state_q != ST_HELD) && !rst;
  assign ack_s    = bus.imem_ack && req_s;
  assign target_s = {bus.EX_MEM_NPC[31:2], 2'b00};
  assign pc_inc_s = pc_q + 32'd4;

  assign bus.imem_req    = req_s;
  assign bus.imem_addr   = (state_q == ST_DRAIN) ? kill_addr_q : pc_q;
  assign bus.IF_ID_Instr = if_id_instr_q;
  assign bus.IF_ID_NPC   = if_id_npc_q;
  assign bus.IF_ID_valid = if_id_valid_q;

  // Next-state: redirect beats stall, stall beats load, load beats bubble.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_addr_d   = kill_addr_q;
    buf_instr_d   = buf_instr_q;
    buf_npc_d     = buf_npc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_npc_d   = if_id_npc_q;
    if_id_valid_d = if_id_valid_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.PCSrc) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          pc_d          = target_s;
          if (ack_s) begin
            state_d = ST_FETCH;
          end else begin
            kill_addr_d = pc_q;
            state_d     = ST_DRAIN;
          end
        end else if (ack_s) begin
          pc_d = pc_inc_s;
          if (bus.stall) begin
            buf_instr_d = bus.imem_rdata;
            buf_npc_d   = pc_inc_s;
            state_d     = ST_HELD;
          end else begin
            if_id_instr_d = bus.imem_rdata;
            if_id_npc_d   = pc_inc_s;
            if_id_valid_d = 1'b1;
          end
        end else if (bus.stall) begin
          if_id_valid_d = if_id_valid_q;
        end else begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end
      ST_HELD: begin
        if (bus.PCSrc) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          pc_d          = target_s;
          state_d       = ST_FETCH;
        end else if (bus.stall) begin
          state_d = ST_HELD;
        end else begin
          if_id_instr_d = buf_instr_q;
          if_id_npc_d   = buf_npc_q;
          if_id_valid_d = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // The killed request's data never reaches IF/ID; only its ack ends the drain.
        if (bus.PCSrc) begin
          pc_d          = target_s;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (bus.stall) begin
          if_id_valid_d = if_id_valid_q;
        end else begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
        if (ack_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d       = ST_FETCH;
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      kill_addr_q   <= 32'h0000_0000;
      buf_instr_q   <= 32'h0000_0000;
      buf_npc_q     <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_npc_q   <= 32'h0000_0000;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_addr_q   <= kill_addr_d;
      buf_instr_q   <= buf_instr_d;
      buf_npc_q     <= buf_npc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_npc_q   <= if_id_npc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

endmodule

// File: tb/tb_i_fetch_unit.sv
// Directed, table-driven bench for i_fetch_unit plus hand-written reset sequences.
module tb_i_fetch_unit;

  logic clk;
  logic rst;
  i_fetch_unit_if bus ();

  i_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_npc;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] npc,
                            input logic valid);
    check({tag, " instr"}, bus.IF_ID_Instr, instr);
    check({tag, " npc"}, bus.IF_ID_NPC, npc);
    check({tag, " valid"}, {31'd0, bus.IF_ID_valid}, {31'd0, valid});
  endtask

  initial begin
    // Inputs for the cycle; request/address seen during it; IF/ID after its edge.
    //           stall pcsrc npc            ack   rdata          req   addr           instr          npc            valid
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0000, 1'b1, 32'h0,         32'hA000_0000, 32'h4,         1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0004, 1'b1, 32'h4,         32'hA000_0004, 32'h8,         1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0008, 1'b1, 32'h8,         32'hA000_0008, 32'hC,         1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,         32'h0,         32'hC,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hC,         32'h0,         32'hC,         1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_000C, 1'b1, 32'hC,         32'hA000_000C, 32'h10,        1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0010, 1'b1, 32'h10,        32'hA000_000C, 32'h10,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h14,        32'hA000_000C, 32'h10,        1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h14,        32'hA000_000C, 32'h10,        1'b1};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h14,        32'hA000_0010, 32'h14,        1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0014, 1'b1, 32'h14,        32'hA000_0014, 32'h18,        1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h40,        1'b0, 32'h0,         1'b1, 32'h18,        32'h0,         32'h18,        1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h18,        32'h0,         32'h18,        1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0018, 1'b1, 32'h18,        32'h0,         32'h18,        1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0040, 1'b1, 32'h40,        32'hA000_0040, 32'h44,        1'b1};
    vecs[15] = '{1'b0, 1'b1, 32'h103,       1'b0, 32'h0,         1'b1, 32'h44,        32'h0,         32'h44,        1'b0};
    vecs[16] = '{1'b0, 1'b1, 32'h200,       1'b0, 32'h0,         1'b1, 32'h44,        32'h0,         32'h44,        1'b0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 1'b1, 32'h44,        32'h0,         32'h44,        1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0200, 1'b1, 32'h200,       32'hA000_0200, 32'h204,       1'b1};
    vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0204, 1'b1, 32'h204,       32'hA000_0200, 32'h204,       1'b1};
    vecs[20] = '{1'b1, 1'b1, 32'h80,        1'b0, 32'h0,         1'b0, 32'h208,       32'h0,         32'h204,       1'b0};
    vecs[21] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0080, 1'b1, 32'h80,        32'hA000_0080, 32'h84,        1'b1};
    vecs[22] = '{1'b0, 1'b1, 32'h300,       1'b1, 32'hA000_0084, 1'b1, 32'h84,        32'h0,         32'h84,        1'b0};
    vecs[23] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h300,       32'h0,         32'h84,        1'b0};
    vecs[24] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hA000_0300, 1'b1, 32'h300,       32'h0,         32'h84,        1'b0};
    vecs[25] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hAFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hAFFF_FFFC, 32'h0,         1'b1};
    vecs[26] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hA000_0000, 1'b1, 32'h0,         32'hA000_0000, 32'h4,         1'b1};
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall      = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.EX_MEM_NPC = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("reset req", {31'd0, bus.imem_req}, 32'd0);
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      bus.stall      = vecs[i].stall;
      bus.PCSrc      = vecs[i].pcsrc;
      bus.EX_MEM_NPC = vecs[i].npc;
      bus.imem_ack   = vecs[i].ack;
      bus.imem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d addr", i), bus.imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check_ifid($sformatf("v%0d", i), vecs[i].exp_instr, vecs[i].exp_npc, vecs[i].exp_valid);
    end

    // Outstanding request at 4, then async reset mid-cycle.
    bus.stall = 1'b0;
    bus.PCSrc = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    #1;
    check("pre-rst req", {31'd0, bus.imem_req}, 32'd1);
    check("pre-rst addr", bus.imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    check("async rst req", {31'd0, bus.imem_req}, 32'd0);
    check("async rst addr", bus.imem_addr, 32'h0);
    check_ifid("async rst", 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Late ack right after release is taken as the reset-PC fetch.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hA000_0000;
    #1;
    check("post-rst req", {31'd0, bus.imem_req}, 32'd1);
    check("post-rst addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    check_ifid("post-rst", 32'hA000_0000, 32'h4, 1'b1);
    bus.imem_ack = 1'b0;
    #1;
    check("post-rst next addr", bus.imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_fetch_unit.md
Name: i_fetch_unit

Overview:
- MIPS IF (fetch) pipeline stage; produces the IF/ID pipeline register (`IF_ID_Instr`, `IF_ID_NPC`) consumed by the decode stage.
- Owns the PC and issues instruction-memory reads over a req/ack handshake that may take several cycles.
- Honours the hazard-unit stall and the branch redirect (`PCSrc`, target from EX/MEM).
- Buffers one returned instruction while stalled, and drains a killed in-flight request after a redirect.

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, bubble instruction word driven into IF/ID.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hazard unit: hold IF/ID and stop the PC advancing.
- `PCSrc`  in  1  branch taken; redirect fetch to `EX_MEM_NPC`.
- `EX_MEM_NPC`  in  32  branch target address.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  32  read address; word aligned.
- `imem_ack`  in  1  one-cycle pulse; read data valid this cycle.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_ack`=1.
- `IF_ID_Instr`  out  32  IF/ID instruction register.
- `IF_ID_NPC`  out  32  IF/ID next-PC register (fetch address + 4).
- `IF_ID_valid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (async, `rst`=1):
  - PC=`RESET_PC`, state=FETCH.
  - `IF_ID_Instr`=`NOP_INSTR`, `IF_ID_NPC`=0, `IF_ID_valid`=0.
  - Skid buffer empty; `imem_req`=0 while `rst` is high.
- Memory protocol:
  - A request is outstanding from the first cycle `imem_req`=1 until the cycle `imem_ack`=1.
  - `imem_addr` stays stable while the request is outstanding.
  - Exactly one request is outstanding at a time. `imem_ack` while `imem_req`=0 is ignored.
- Registers:
  - PC (32).
  - `kill_addr` (32).
  - Skid buffer: `buf_instr` (32), `buf_npc` (32).
  - 2-bit state: FETCH, HELD, DRAIN.
- FETCH: `imem_req`=1, `imem_addr`=PC.
  - `PCSrc`=1 with `imem_ack`=1: discard data; PC<=`EX_MEM_NPC`; stay FETCH.
  - `PCSrc`=1 without `imem_ack`: `kill_addr`<=PC; PC<=`EX_MEM_NPC`; go to DRAIN.
  - `imem_ack`=1 with `stall`=0: IF/ID<={`imem_rdata`, PC+4, valid=1}; PC<=PC+4.
  - `imem_ack`=1 with `stall`=1: buffer<={`imem_rdata`, PC+4}; PC<=PC+4; go to HELD. IF/ID holds.
  - No `imem_ack`, `stall`=0: IF/ID<=bubble (`NOP_INSTR`, NPC unchanged, valid=0).
  - No `imem_ack`, `stall`=1: IF/ID holds.
- HELD: `imem_req`=0.
  - `PCSrc`=1: drop buffer; PC<=`EX_MEM_NPC`; go to FETCH.
  - `stall`=0: IF/ID<={`buf_instr`, `buf_npc`, valid=1}; go to FETCH.
  - `stall`=1: everything holds.
- DRAIN: `imem_req`=1, `imem_addr`=`kill_addr`.
  - `imem_ack`=1: data discarded; go to FETCH.
  - `PCSrc`=1 in DRAIN: PC<=`EX_MEM_NPC` (latest target wins); stay DRAIN unless ack arrives the same cycle.
- Priority of IF/ID updates: `PCSrc` (load bubble, regardless of `stall`) > `stall` (hold) > load instruction > bubble.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `EX_MEM_NPC` bits [1:0] are forced to 0 on load.
- `PCSrc` and `stall` asserted together: redirect wins; `stall` is ignored that cycle.
- Reset mid-request: state returns to FETCH; a late `imem_ack` in the first cycle after reset release with `imem_req`=1 is accepted as the `RESET_PC` fetch.
  - The memory model must therefore abort on reset.
- Latency:
  - Memory ack in cycle N → `IF_ID_Instr` visible after edge N.
  - Zero-wait memory (ack the same cycle as req) → one instruction per cycle.

Test Plan:
1. Reset release, memory acks every cycle returning addr|0xA000_0000, no stall → IF/ID sequence NPC=4,8,12 with Instr=0xA000_0000,0xA000_0004,0xA000_0008; valid=1 every cycle from first ack.
2. Memory 3-cycle latency → `imem_addr`=0 held 3 cycles; IF/ID shows 2 bubble cycles (valid=0, Instr=0); then Instr=mem[0], NPC=4.
3. Ack at PC=8 while `stall`=1 for 2 cycles → `imem_req`=0 in HELD; IF/ID unchanged; after stall drops, IF/ID={mem[8], 12, 1}; next request addr=12.
4. `PCSrc`=1, target 0x40, during outstanding fetch of 0x10 (no ack) → `imem_addr` stays 0x10 until ack; data discarded, IF/ID bubble; next request addr=0x40; then IF/ID NPC=0x44.
5. `PCSrc` and `stall` both high in HELD → buffer dropped; IF/ID bubble; next fetch addr=target.
6. PC=0xFFFF_FFFC, ack → IF/ID NPC=0; next `imem_addr`=0. Assert `rst` mid-request → all outputs reach reset values immediately, without waiting for a clock edge.
